pipelined_add_sub: RTL and testbench
====================================

# pipelined_add_sub

Parametrised, pipelined add/subtract unit: the next generation of the team's 32-bit behavioural full adder. It computes `A + B + Cin` or `A - B - Cin` over `WIDTH` bits. The carry chain is split into `STAGES` registered slices, so wide operands close timing at high clock rates, and it adds valid/ready flow control plus status flags. It sits in the datapath as the ALU's add/sub engine and accepts one operation per cycle.

## Interface
- `WIDTH`, 32: operand/result width; must be a multiple of `STAGES`.
- `STAGES`, 4: pipeline depth; the carry chain is cut into `STAGES` slices of `WIDTH/STAGES` bits. Legal range 1..WIDTH.
- `clk`, in, 1: clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `InValid`, in, 1: input operation valid.
- `InReady`, out, 1: unit can accept an operation this cycle.
- `A`, in, WIDTH: operand A.
- `B`, in, WIDTH: operand B.
- `Cin`, in, 1: carry-in (add) / borrow-in (sub).
- `Sub`, in, 1: 0 = add, 1 = subtract.
- `OutValid`, out, 1: result valid.
- `OutReady`, in, 1: downstream accepts the result.
- `Sum`, out, WIDTH: result.
- `Cout`, out, 1: carry-out (add); NOT borrow (sub).
- `Overflow`, out, 1: signed two's-complement overflow.
- `Zero`, out, 1: `Sum == 0`.

## Operation
- Effective operands: `Bx = Sub ? ~B : B`; `Cx = Sub ? ~Cin : Cin`. The unit computes `{Cout, Sum} = A + Bx + Cx` at WIDTH+1 bits.
  - Add: `A + B + Cin`.
  - Sub: `A - B - Cin`, i.e. `A + ~B + !Cin`. `Cout = 1` means no borrow.
- Slice k (k = 0..STAGES-1) covers bits `[(k+1)*W-1 : k*W]`, where `W = WIDTH/STAGES`.
- Stage k adds slice k of A and Bx plus the carry registered by stage k-1; stage 0 uses `Cx`.
- Each stage registers:
  - completed low slices of Sum;
  - carry into the next slice;
  - unconsumed high slices of A and Bx;
  - sign bits `A[WIDTH-1]` and `Bx[WIDTH-1]`;
  - a valid bit.
- Final stage produces the outputs:
  - `Overflow = (A[MSB] == Bx[MSB]) && (Sum[MSB] != A[MSB])`;
  - `Zero = ~|Sum`;
  - `Cout` = carry out of the top slice.
- Flow control: global advance `Adv = !OutValid || OutReady`.
  - `InReady = Adv`. This is a combinational path from `OutReady`, and is permitted.
  - When `Adv = 1`, all stages shift one step. Stage 0 loads `InValid` as its valid bit.
  - When `Adv = 0`, every stage register holds. No bubbles are inserted and no data is lost.
- An operation is accepted when `InValid && InReady`. A result is consumed when `OutValid && OutReady`.
- Bubbles (`InValid = 0` while advancing) propagate as invalid slots. A result never appears without a corresponding accepted input, and appears exactly once.
- Data registers of invalid slots are don't-care internally. The outputs are nonetheless defined below.

## Timing
- Reset: on any rising edge with `rst = 1`:
  - all valid bits clear;
  - `OutValid = 0`, `Sum = 0`, `Cout = 0`, `Overflow = 0`, `Zero = 0`;
  - `InReady = 1` in the following cycle.
- Reset mid-operation flushes all in-flight operations; they are never output. `rst` has priority over `Adv`.
- Latency: an operation accepted at edge n appears with `OutValid = 1` after edge n+STAGES-1. With `STAGES = 1`, the result is registered once and is valid the cycle after acceptance.
- Throughput: one operation per cycle while `OutReady = 1`.
- Output hold: while `OutValid && !OutReady`, `Sum`/`Cout`/`Overflow`/`Zero` are stable and `InReady = 0`.
- Outputs are registered, with no combinational path from A/B/Cin/Sub to outputs.
- When `OutValid = 0`, Sum and flags hold their last value (0 after reset).
- Back-to-back: acceptance and consumption in the same cycle is legal at full rate.
- Wrap-around:
  - `0xFFFFFFFF + 1` gives `Sum = 0`, `Cout = 1`, `Zero = 1`.
  - The carry must propagate correctly across every slice boundary.

## Test plan
- Reset, then add `A = 0x0000_0005`, `B = 0x0000_0003`, `Cin = 1`, `Sub = 0` → exactly 4 cycles later `OutValid = 1`, `Sum = 0x9`, `Cout = 0`, `Overflow = 0`, `Zero = 0`.
- Full carry ripple: `A = 0xFFFF_FFFF`, `B = 0`, `Cin = 1`, add → `Sum = 0`, `Cout = 1`, `Zero = 1`.
- Sub and overflow:
  - `A = 5`, `B = 7`, `Cin = 0`, `Sub = 1` → `Sum = 0xFFFF_FFFE`, `Cout = 0`.
  - `A = 0x7FFF_FFFF`, `B = 1`, add → `Sum = 0x8000_0000`, `Overflow = 1`.
  - `A = 0x8000_0000`, `B = 1`, sub → `Sum = 0x7FFF_FFFF`, `Overflow = 1`, `Cout = 1`.
- Streaming with backpressure:
  - Issue 10 back-to-back random operations.
  - Hold `OutReady = 0` for 3 cycles mid-stream.
  - Required: `InReady = 0` during the stall, outputs stable, all 10 results in order and matching the model, no duplicates.
- Reset mid-flight: accept 3 operations, assert `rst` for 1 cycle before any output → `OutValid` stays 0 and none of the 3 results ever appears. A new operation after reset returns correctly with 4-cycle latency.
- Parameter sweep: `WIDTH/STAGES` = 8/1, 16/4, 64/8 with random add/sub versus a WIDTH+1-bit reference model → all results and flags match; latency equals `STAGES`.

Source files
------------

// File: rtl/pipelined_add_sub.sv
// Pipelined WIDTH-bit add/subtract; carry chain cut into STAGES registered slices, latency STAGES cycles.
// Backpressure: one global advance (!OutValid || OutReady) shifts or freezes every stage; InReady follows it.
module pipelined_add_sub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Overflow,
    output logic             Zero
);

    localparam int W    = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    logic [WIDTH-1:0] sum_q   [STAGES];
    logic [WIDTH-1:0] sum_d   [STAGES];
    logic [WIDTH-1:0] a_q     [STAGES];
    logic [WIDTH-1:0] a_d     [STAGES];
    logic [WIDTH-1:0] bx_q    [STAGES];
    logic [WIDTH-1:0] bx_d    [STAGES];
    logic             carry_q [STAGES];
    logic             carry_d [STAGES];
    logic             vld_q   [STAGES];
    logic             vld_d   [STAGES];
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             adv;

    // Stage inputs: stage 0 sees the ports, stage k sees stage k-1's registers.
    logic [WIDTH-1:0] si_sum [STAGES];
    logic [WIDTH-1:0] si_a   [STAGES];
    logic [WIDTH-1:0] si_bx  [STAGES];
    logic             si_c   [STAGES];
    logic             si_v   [STAGES];
    logic [W:0]       slice_sum;

    always_comb begin
        adv       = !vld_q[LAST] || OutReady;
        slice_sum = '0;

        si_sum[0] = '0;
        si_a[0]   = A;
        si_bx[0]  = Sub ? ~B : B;
        si_c[0]   = Sub ? ~Cin : Cin;
        si_v[0]   = InValid;
        for (int k = 1; k < STAGES; k++) begin
            si_sum[k] = sum_q[k-1];
            si_a[k]   = a_q[k-1];
            si_bx[k]  = bx_q[k-1];
            si_c[k]   = carry_q[k-1];
            si_v[k]   = vld_q[k-1];
        end

        for (int k = 0; k < STAGES; k++) begin
            slice_sum = {1'b0, si_a[k][k*W +: W]} + {1'b0, si_bx[k][k*W +: W]}
                      + (W+1)'(si_c[k]);
            sum_d[k]            = si_sum[k];
            sum_d[k][k*W +: W]  = slice_sum[W-1:0];
            carry_d[k]          = slice_sum[W];
            a_d[k]              = si_a[k];
            bx_d[k]             = si_bx[k];
            vld_d[k]            = si_v[k];
        end

        ovf_d  = (si_a[LAST][WIDTH-1] == si_bx[LAST][WIDTH-1]) &&
                 (sum_d[LAST][WIDTH-1] != si_a[LAST][WIDTH-1]);
        zero_d = ~|sum_d[LAST];
    end

    // Data only loads with a valid slot so the outputs hold their last result across bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k]   <= 1'b0;
                sum_q[k]   <= '0;
                a_q[k]     <= '0;
                bx_q[k]    <= '0;
                carry_q[k] <= 1'b0;
            end
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k] <= vld_d[k];
                if (vld_d[k]) begin
                    sum_q[k]   <= sum_d[k];
                    a_q[k]     <= a_d[k];
                    bx_q[k]    <= bx_d[k];
                    carry_q[k] <= carry_d[k];
                end
            end
            if (vld_d[LAST]) begin
                ovf_q  <= ovf_d;
                zero_q <= zero_d;
            end
        end
    end

    assign InReady  = adv;
    assign OutValid = vld_q[LAST];
    assign Sum      = sum_q[LAST];
    assign Cout     = carry_q[LAST];
    assign Overflow = ovf_q;
    assign Zero     = zero_q;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Scoreboard bench: 32/4 unit with directed, streaming, stall and mid-flight reset steps,
// plus 8/1 and 64/8 instances swept with random operations against a wide reference model.
module tb_pipelined_add_sub;

    typedef struct {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_vld, in_rdy, cin, sub, out_vld, out_rdy, cout, ovf, zero;
    logic [31:0] a, b, sum;

    logic        rst_aux, rdy_aux;
    logic        v1, r1, c1, s1, ov1, co1, of1, z1;
    logic [7:0]  a1, b1, sum1;
    logic        v2, r2, c2, s2, ov2, co2, of2, z2;
    logic [63:0] a2, b2, sum2;

    pipelined_add_sub #(.WIDTH(32), .STAGES(4)) dut (
        .clk(clk), .rst(rst), .InValid(in_vld), .InReady(in_rdy), .A(a), .B(b),
        .Cin(cin), .Sub(sub), .OutValid(out_vld), .OutReady(out_rdy), .Sum(sum),
        .Cout(cout), .Overflow(ovf), .Zero(zero));

    pipelined_add_sub #(.WIDTH(8), .STAGES(1)) dut1 (
        .clk(clk), .rst(rst_aux), .InValid(v1), .InReady(r1), .A(a1), .B(b1),
        .Cin(c1), .Sub(s1), .OutValid(ov1), .OutReady(rdy_aux), .Sum(sum1),
        .Cout(co1), .Overflow(of1), .Zero(z1));

    pipelined_add_sub #(.WIDTH(64), .STAGES(8)) dut2 (
        .clk(clk), .rst(rst_aux), .InValid(v2), .InReady(r2), .A(a2), .B(b2),
        .Cin(c2), .Sub(s2), .OutValid(ov2), .OutReady(rdy_aux), .Sum(sum2),
        .Cout(co2), .Overflow(of2), .Zero(z2));

    exp_t        q0[$], q1[$], q2[$];
    int          cyc, n_chk, n_pass, n_stall, n_cons;
    bit          lat_chk, use_dir, acc0, prev_stall;
    exp_t        dir_exp;
    logic [31:0] prev_sum;
    logic [2:0]  prev_flags;

    function automatic exp_t model(input int w, input logic [63:0] av, input logic [63:0] bv,
                                   input logic ci, input logic sb);
        exp_t        e;
        logic [64:0] r;
        logic [63:0] m, am, bx;
        logic        cx;
        m      = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        am     = av & m;
        bx     = (sb ? ~bv : bv) & m;
        cx     = sb ? ~ci : ci;
        r      = {1'b0, am} + {1'b0, bx} + {64'd0, cx};
        e.sum  = r[63:0] & m;
        e.cout = r[w];
        e.ovf  = (am[w-1] == bx[w-1]) && (e.sum[w-1] != am[w-1]);
        e.zero = (e.sum == 64'd0);
        e.due  = 0;
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: got %0h, want %0h", tag, obs, expv);
    endtask

    task automatic cmp_res(input string tag, input exp_t e, input logic [63:0] s,
                           input logic c, input logic o, input logic z);
        check({tag, ".sum"}, s, e.sum);
        check({tag, ".cout"}, 64'(c), 64'(e.cout));
        check({tag, ".ovf"}, 64'(o), 64'(e.ovf));
        check({tag, ".zero"}, 64'(z), 64'(e.zero));
        if (e.due >= 0) check({tag, ".latency"}, 64'(cyc), 64'(e.due));
    endtask

    // One clock: sample at negedge, score, then advance to just after the next rising edge.
    task automatic step();
        exp_t e;
        @(negedge clk);
        if (out_vld && out_rdy) begin
            check("main.expected_output", 64'(q0.size() > 0), 64'd1);
            if (q0.size() > 0) begin
                e = q0.pop_front();
                cmp_res("main", e, {32'd0, sum}, cout, ovf, zero);
                n_cons++;
            end
        end
        if (out_vld && !out_rdy) begin
            n_stall++;
            check("stall.in_ready", 64'(in_rdy), 64'd0);
            if (prev_stall) begin
                check("stall.sum_stable", {32'd0, sum}, {32'd0, prev_sum});
                check("stall.flags_stable", 64'({cout, ovf, zero}), 64'(prev_flags));
            end
            prev_stall = 1'b1;
            prev_sum   = sum;
            prev_flags = {cout, ovf, zero};
        end else begin
            prev_stall = 1'b0;
        end
        acc0 = in_vld && in_rdy && !rst;
        if (rst) q0.delete();
        else if (acc0) begin
            e     = use_dir ? dir_exp : model(32, {32'd0, a}, {32'd0, b}, cin, sub);
            e.due = lat_chk ? cyc + 4 : -1;
            q0.push_back(e);
        end

        if (ov1) begin
            check("w8s1.expected_output", 64'(q1.size() > 0), 64'd1);
            if (q1.size() > 0) begin
                e = q1.pop_front();
                cmp_res("w8s1", e, {56'd0, sum1}, co1, of1, z1);
            end
        end
        if (v1 && r1 && !rst_aux) begin
            e     = model(8, {56'd0, a1}, {56'd0, b1}, c1, s1);
            e.due = cyc + 1;
            q1.push_back(e);
        end
        if (ov2) begin
            check("w64s8.expected_output", 64'(q2.size() > 0), 64'd1);
            if (q2.size() > 0) begin
                e = q2.pop_front();
                cmp_res("w64s8", e, sum2, co2, of2, z2);
            end
        end
        if (v2 && r2 && !rst_aux) begin
            e     = model(64, a2, b2, c2, s2);
            e.due = cyc + 8;
            q2.push_back(e);
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic dir_op(input logic [31:0] av, input logic [31:0] bv, input logic ci,
                          input logic sb, input logic [31:0] es, input logic ec,
                          input logic eo, input logic ez);
        in_vld = 1'b1; a = av; b = bv; cin = ci; sub = sb;
        use_dir = 1'b1;
        dir_exp.sum = {32'd0, es}; dir_exp.cout = ec; dir_exp.ovf = eo; dir_exp.zero = ez;
        dir_exp.due = 0;
        step();
        in_vld = 1'b0; use_dir = 1'b0;
        repeat (5) step();
        check("dir.drained", 64'(q0.size()), 64'd0);
    endtask

    initial begin
        cyc = 0; n_chk = 0; n_pass = 0; n_stall = 0; n_cons = 0;
        lat_chk = 1'b1; use_dir = 1'b0; acc0 = 1'b0; prev_stall = 1'b0;
        prev_sum = '0; prev_flags = '0; dir_exp = '{default: 0};
        rst = 1'b1; rst_aux = 1'b1; rdy_aux = 1'b1; out_rdy = 1'b1;
        in_vld = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        v1 = 1'b0; a1 = '0; b1 = '0; c1 = 1'b0; s1 = 1'b0;
        v2 = 1'b0; a2 = '0; b2 = '0; c2 = 1'b0; s2 = 1'b0;
        step(); step();
        rst = 1'b0; rst_aux = 1'b0;

        check("rst.out_valid", 64'(out_vld), 64'd0);
        check("rst.sum", {32'd0, sum}, 64'd0);
        check("rst.flags", 64'({cout, ovf, zero}), 64'd0);
        check("rst.in_ready", 64'(in_rdy), 64'd1);

        dir_op(32'h0000_0005, 32'h0000_0003, 1'b1, 1'b0, 32'h0000_0009, 1'b0, 1'b0, 1'b0);
        dir_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        dir_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        dir_op(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        dir_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        dir_op(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);

        // Ten back-to-back operations with a 3-cycle output stall in the middle.
        lat_chk = 1'b0; n_stall = 0; n_cons = 0;
        begin
            int i, k;
            i = 0; k = 0;
            in_vld = 1'b1; a = $urandom(); b = $urandom();
            cin = ($urandom() & 1) != 0; sub = ($urandom() & 1) != 0;
            while (i < 10 && k < 60) begin
                out_rdy = !(k >= 4 && k < 7);
                step();
                k++;
                if (acc0) begin
                    i++;
                    a = $urandom(); b = $urandom();
                    cin = ($urandom() & 1) != 0; sub = ($urandom() & 1) != 0;
                end
            end
            in_vld = 1'b0; out_rdy = 1'b1;
            check("stream.accepted", 64'(i), 64'd10);
            k = 0;
            while (q0.size() > 0 && k < 20) begin
                step();
                k++;
            end
        end
        check("stream.drained", 64'(q0.size()), 64'd0);
        check("stream.consumed", 64'(n_cons), 64'd10);
        check("stream.stall_cycles", 64'(n_stall), 64'd3);

        // Reset lands before the first of three in-flight results can emerge.
        lat_chk = 1'b1;
        repeat (3) begin
            in_vld = 1'b1; a = $urandom(); b = $urandom();
            cin = ($urandom() & 1) != 0; sub = ($urandom() & 1) != 0;
            step();
        end
        in_vld = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        check("rstmid.sum", {32'd0, sum}, 64'd0);
        repeat (6) begin
            check("rstmid.out_valid", 64'(out_vld), 64'd0);
            step();
        end
        dir_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0);

        // Width/depth sweep on the 8/1 and 64/8 instances, opening with full carry ripples.
        for (int j = 0; j < 40; j++) begin
            if (j == 0) begin
                v1 = 1'b1; a1 = 8'hFF; b1 = 8'h00; c1 = 1'b1; s1 = 1'b0;
                v2 = 1'b1; a2 = '1;    b2 = '0;    c2 = 1'b1; s2 = 1'b0;
            end else begin
                v1 = ($urandom() % 5) != 0;
                a1 = 8'($urandom()); b1 = 8'($urandom());
                c1 = ($urandom() & 1) != 0; s1 = ($urandom() & 1) != 0;
                v2 = ($urandom() % 5) != 0;
                a2 = {$urandom(), $urandom()}; b2 = {$urandom(), $urandom()};
                c2 = ($urandom() & 1) != 0; s2 = ($urandom() & 1) != 0;
            end
            step();
        end
        v1 = 1'b0; v2 = 1'b0;
        repeat (10) step();
        check("w8s1.drained", 64'(q1.size()), 64'd0);
        check("w64s8.drained", 64'(q2.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
